// File: rtl/axi_sram_bridge.sv
// AXI4 slave to single-port SRAM bridge: serialises read and write bursts
// onto a 1-cycle-latency, always-granted SRAM with fair read/write alternation.
module axi_sram_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned MEM_ADDR_WIDTH = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    input  logic                        aw_valid,
    output logic                        aw_ready,

    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    input  logic                        w_valid,
    output logic                        w_ready,

    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    output logic                        b_valid,
    input  logic                        b_ready,

    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    input  logic                        ar_valid,
    output logic                        ar_ready,

    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    output logic                        r_valid,
    input  logic                        r_ready,

    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RREQ,
        RDATA
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                      state_q, state_d;
    logic                        rd_prio_q;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                  len_q;
    logic [7:0]                  beat_q;
    logic [2:0]                  size_q;
    logic [1:0]                  burst_q;
    logic                        err_q;
    logic                        rd_first_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;

    logic                        aw_hs;
    logic                        ar_hs;
    logic                        w_hs;
    logic                        r_hs;
    logic                        last_beat;
    logic [AXI_ADDR_WIDTH-1:0]   addr_next;
    logic                        unused_inputs;

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

    // Only one ready can be high when both address valids are present.
    assign aw_ready  = (state_q == IDLE) && !(ar_valid && rd_prio_q);
    assign ar_ready  = (state_q == IDLE) && !(aw_valid && !rd_prio_q);
    assign aw_hs     = aw_valid && aw_ready;
    assign ar_hs     = ar_valid && ar_ready && !aw_hs;
    assign w_hs      = (state_q == WRITE) && w_valid;
    assign r_hs      = (state_q == RDATA) && r_ready;
    assign last_beat = (beat_q == len_q);

    // WRAP bursts are treated as INCR.
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q
                     : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);

    assign mem_addr_o = addr_q[MEM_ADDR_WIDTH+1:2];
    assign b_id       = id_q;
    assign b_user     = '0;
    assign r_id       = id_q;
    assign r_resp     = RESP_OKAY;
    assign r_user     = '0;
    // SRAM data lands in the first RDATA cycle; the hold register covers stalls.
    assign r_data     = rd_first_q ? mem_rdata_i : rdata_q;

    assign unused_inputs = ^{aw_user, w_user, ar_user};

    always_comb begin
        state_d     = state_q;
        w_ready     = 1'b0;
        b_valid     = 1'b0;
        b_resp      = RESP_OKAY;
        r_valid     = 1'b0;
        r_last      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        case (state_q)
            IDLE: begin
                if (aw_hs)      state_d = WRITE;
                else if (ar_hs) state_d = RREQ;
            end
            WRITE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_wdata_o = w_data;
                    mem_be_o    = w_strb;
                    if (last_beat) state_d = WRESP;
                end
            end
            WRESP: begin
                b_valid = 1'b1;
                b_resp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (b_ready) state_d = IDLE;
            end
            RREQ: begin
                mem_req_o = 1'b1;
                state_d   = RDATA;
            end
            RDATA: begin
                r_valid = 1'b1;
                r_last  = last_beat;
                if (r_ready) state_d = last_beat ? IDLE : RREQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_prio_q  <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            rd_first_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_first_q <= (state_q == RREQ);
            if (rd_first_q) rdata_q <= mem_rdata_i;

            if (aw_hs) begin
                id_q      <= aw_id;
                addr_q    <= aw_addr;
                len_q     <= aw_len;
                size_q    <= clamp_size(aw_size);
                burst_q   <= aw_burst;
                beat_q    <= '0;
                err_q     <= 1'b0;
                rd_prio_q <= 1'b1;
            end else if (ar_hs) begin
                id_q      <= ar_id;
                addr_q    <= ar_addr;
                len_q     <= ar_len;
                size_q    <= clamp_size(ar_size);
                burst_q   <= ar_burst;
                beat_q    <= '0;
                err_q     <= 1'b0;
                rd_prio_q <= 1'b0;
            end

            if (w_hs) begin
                err_q <= err_q | (w_last != last_beat);
                if (!last_beat) begin
                    beat_q <= beat_q + 8'd1;
                    addr_q <= addr_next;
                end
            end

            if (r_hs && !last_beat) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= addr_next;
            end
        end
    end

endmodule
